// File: rtl/rhs_pkg.sv
// rtl/rhs_pkg.sv - shared constants and frame state encoding for the rhs_256 datapath
package rhs_pkg;

    localparam int RHS_CHIPS       = 16;
    localparam int RHS_CH_PER_CHIP = 16;

    localparam logic [15:0] FRAME_MAGIC = 16'hA5C3;
    localparam int          FRAME_WORDS = 130;

    typedef enum logic [2:0] {
        HUNT,
        HDR0,
        HDR1,
        DATA,
        WAIT,
        DROP
    } frame_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with occupancy output
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_wr;
    logic             do_rd;

    assign do_wr    = wr_en && (level_q != LW'(DEPTH));
    assign do_rd    = rd_en && (level_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (level_q != '0);
    assign level    = level_q;

    // Storage carries no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/rhs_frame_assembler.sv
// rtl/rhs_frame_assembler.sv - packs 16-slot sweeps into 130-word frames streamed through a FIFO
module rhs_frame_assembler
    import rhs_pkg::*;
#(
    parameter int FIFO_DEPTH = 512
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic                          sample_valid,
    input  logic [7:0]                    sample_channel,
    input  logic [255:0]                  sample_data,
    output logic [31:0]                   m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    input  logic                          status_clear,
    output logic                          sync_err,
    output logic [15:0]                   dropped_frames,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    frame_state_t   state_q;
    logic [255:0]   stage_q;
    logic [3:0]     slot_q;
    logic [2:0]     word_q;
    logic [31:0]    frame_count_q;
    logic [15:0]    dropped_q;
    logic           sync_err_q;
    logic           cur_mis_q;
    logic           prev_sync_q;

    logic           slot_v;
    logic           is_ch0;
    logic           is_ch15;
    logic           room;
    logic           slot_mis;
    logic           sync_set;
    logic           wr_en;
    logic [32:0]    wr_word;
    logic [32:0]    fifo_rd;
    logic           fifo_valid;

    assign slot_v   = sample_valid && (sample_channel < 8'd16);
    assign is_ch0   = slot_v && (sample_channel == 8'd0);
    assign is_ch15  = slot_v && (sample_channel == 8'd15);
    assign room     = (FIFO_DEPTH - int'(fifo_level)) >= FRAME_WORDS;
    assign slot_mis = (state_q == WAIT) && slot_v &&
                      (sample_channel != {4'd0, slot_q + 4'd1});
    assign sync_set = slot_mis ||
                      (slot_v && (state_q == HDR0 || state_q == HDR1 || state_q == DATA));

    always_comb begin
        wr_en   = 1'b0;
        wr_word = '0;
        case (state_q)
            HDR0: begin
                wr_en   = 1'b1;
                wr_word = {1'b0, FRAME_MAGIC, prev_sync_q, 7'd0, dropped_q[7:0]};
            end
            HDR1: begin
                wr_en   = 1'b1;
                wr_word = {1'b0, frame_count_q};
            end
            DATA: begin
                wr_en   = 1'b1;
                wr_word = {(word_q == 3'd7) && (slot_q == 4'd15),
                           stage_q[{word_q, 5'd0} +: 32]};
            end
            default: begin
                wr_en   = 1'b0;
                wr_word = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= HUNT;
            stage_q       <= '0;
            slot_q        <= '0;
            word_q        <= '0;
            frame_count_q <= '0;
            dropped_q     <= '0;
            sync_err_q    <= 1'b0;
            cur_mis_q     <= 1'b0;
            prev_sync_q   <= 1'b0;
        end else begin
            case (state_q)
                HUNT, DROP: begin
                    if (is_ch0) begin
                        if (!enable) begin
                            state_q <= HUNT;
                        end else if (room) begin
                            stage_q     <= sample_data;
                            slot_q      <= 4'd0;
                            word_q      <= 3'd0;
                            prev_sync_q <= cur_mis_q;
                            cur_mis_q   <= 1'b0;
                            state_q     <= HDR0;
                        end else begin
                            if (dropped_q != 16'hFFFF) begin
                                dropped_q <= dropped_q + 16'd1;
                            end
                            state_q <= DROP;
                        end
                    end else if (state_q == DROP && is_ch15) begin
                        state_q <= HUNT;
                    end
                end
                HDR0: state_q <= HDR1;
                HDR1: begin
                    frame_count_q <= frame_count_q + 32'd1;
                    state_q       <= DATA;
                end
                DATA: begin
                    word_q <= word_q + 3'd1;
                    if (word_q == 3'd7) begin
                        state_q <= (slot_q == 4'd15) ? HUNT : WAIT;
                    end
                end
                WAIT: begin
                    // The counter decides placement; a wrong channel is only flagged.
                    if (slot_v) begin
                        stage_q <= sample_data;
                        slot_q  <= slot_q + 4'd1;
                        state_q <= DATA;
                        if (slot_mis) begin
                            cur_mis_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
            sync_err_q <= !status_clear && (sync_err_q || sync_set);
            if (status_clear) begin
                dropped_q <= '0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_data  (wr_word),
        .rd_en    (m_tready),
        .rd_data  (fifo_rd),
        .rd_valid (fifo_valid),
        .level    (fifo_level)
    );

    assign m_tvalid       = fifo_valid;
    assign m_tdata        = fifo_valid ? fifo_rd[31:0] : 32'd0;
    assign m_tlast        = fifo_valid && fifo_rd[32];
    assign sync_err       = sync_err_q;
    assign dropped_frames = dropped_q;

endmodule
